// File: rtl/param_shift_register.sv
//==============================================================================
// Module      : param_shift_register
// Description : WIDTH-bit register with parallel load and a sequenced
//               one-step-per-cycle shift/rotate engine with busy/done handshake.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module param_shift_register #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] in,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic             sin,
    output logic [WIDTH-1:0] out,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] MODE_SHL = 2'b00;
    localparam logic [1:0] MODE_SHR = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] data_next;
    logic [1:0]       mode_eff;
    logic             accept_start;

    // A sequence is only accepted from idle, with load taking priority
    assign accept_start = (state == ST_IDLE) && start && !ld;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latch mode/amount at sequence start, then count steps down while shifting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_SHL;
            cnt    <= CNT_ZERO;
        end else if (accept_start && (amount != CNT_ZERO)) begin
            mode_q <= mode;
            cnt    <= amount;
        end else if (state == ST_SHIFT) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    // Next-state and next register contents
    always_comb begin
        next_state = state;
        data_next  = out;
        case (state)
            ST_IDLE: begin
                if (ld) begin
                    data_next = in;
                end else if (start) begin
                    next_state = (amount != CNT_ZERO) ? ST_SHIFT : ST_FIN;
                end
            end
            ST_SHIFT: begin
                case (mode_q)
                    MODE_SHL: data_next = {out[WIDTH-2:0], sin};
                    MODE_SHR: data_next = {sin, out[WIDTH-1:1]};
                    MODE_SRA: data_next = {out[WIDTH-1], out[WIDTH-1:1]};
                    MODE_ROR: data_next = {out[0], out[WIDTH-1:1]};
                    default:  data_next = out;
                endcase
                // The step that takes the counter to zero is the last one
                if (cnt == CNT_ONE) begin
                    next_state = ST_FIN;
                end
            end
            ST_FIN: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // One storage cell per bit, cleared asynchronously by reset
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic bit_q;
        // Single bit cell
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                bit_q <= 1'b0;
            end else begin
                bit_q <= data_next[i];
            end
        end
        assign out[i] = bit_q;
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_FIN);

    // Outgoing bit follows the latched mode while shifting, the live mode otherwise
    assign mode_eff = busy ? mode_q : mode;
    assign sout     = (mode_eff == MODE_SHL) ? out[WIDTH-1] : out[0];

endmodule

`default_nettype wire
